// File: rtl/carregador_instrucoes.sv
// carregador_instrucoes: UART boot loader filling a 64-word instruction memory.
// Optional trailing XOR checksum byte: define CARREGADOR_CHECKSUM_EN.
module carregador_instrucoes (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] cpu_pc,
  output logic [31:0] cpu_instrucao,
  output logic        cpu_stall,
  output logic [5:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        load_done,
  output logic        erro
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
`ifdef CARREGADOR_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    RUN   = 3'd4,
    ERRO  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [6:0]  n_words;
  logic [6:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] shift;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        is_sync;
  logic        is_data;
  logic        unused_pc;

  assign is_sync   = rx_valid && (rx_data == 8'h55);
  assign is_data   = rx_valid && (state == DATA);
  assign mem_we    = wr_en;
  assign mem_wdata = wr_data;
  assign unused_pc = ^{cpu_pc[31:8], cpu_pc[1:0]};

`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0] csum;
  logic       last_byte;

  assign last_byte = is_data && (byte_idx == 2'd3)
                  && (word_idx == n_words - 7'd1);

  // XOR of every data byte, restarted whenever a new load begins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum <= 8'h00;
    end else if (state_n == COUNT && state != COUNT) begin
      csum <= 8'h00;
    end else if (is_data) begin
      csum <= csum ^ rx_data;
    end
  end
`else
  logic wr_last;

  // remembers whether the word being written is the final one
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_last <= 1'b0;
    end else if (is_data && byte_idx == 2'd3) begin
      wr_last <= (word_idx == n_words - 7'd1);
    end
  end
`endif

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state and CPU/memory port muxing
  always_comb begin
    state_n       = state;
    cpu_stall     = 1'b1;
    cpu_instrucao = 32'h0000_0000;
    mem_addr      = wr_addr;
    load_done     = 1'b0;
    erro          = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_sync) state_n = COUNT;
      end
      COUNT: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > 8'd64) state_n = ERRO;
          else state_n = DATA;
        end
      end
      DATA: begin
`ifdef CARREGADOR_CHECKSUM_EN
        if (last_byte) state_n = CHECK;
`else
        if (wr_en && wr_last) state_n = RUN;
`endif
      end
`ifdef CARREGADOR_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum) state_n = RUN;
          else state_n = ERRO;
        end
      end
`endif
      RUN: begin
        cpu_stall     = 1'b0;
        cpu_instrucao = mem_rdata;
        mem_addr      = cpu_pc[7:2];
        load_done     = 1'b1;
        if (is_sync) state_n = COUNT;
      end
      ERRO: begin
        erro = 1'b1;
        if (is_sync) state_n = COUNT;
      end
      default: state_n = IDLE;
    endcase
  end

  // byte assembly and the registered one-cycle write port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_words  <= 7'd0;
      word_idx <= 7'd0;
      byte_idx <= 2'd0;
      shift    <= 24'd0;
      wr_addr  <= 6'd0;
      wr_data  <= 32'd0;
      wr_en    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (state == COUNT && rx_valid) begin
        n_words  <= rx_data[6:0];
        word_idx <= 7'd0;
        byte_idx <= 2'd0;
      end
      if (is_data) begin
        shift    <= {shift[15:0], rx_data};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          wr_en    <= 1'b1;
          wr_addr  <= word_idx[5:0];
          wr_data  <= {shift, rx_data};
          word_idx <= word_idx + 7'd1;
        end
      end
    end
  end

endmodule
